pc_fetch_unit: RTL and testbench

- Program-counter and fetch sequencer directly upstream of instruction_memory; drives its word-addressed pcOut and tracks memory read latency.
- Presents instr_valid to the decode/execute side and waits for instr_ack before advancing.
- On ack, selects the next PC (sequential, branch, jump, jump-register) from the decoded fields fed back from downstream.
- Also provides halt and fault states and a retired-instruction counter.

---
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding instruction_memory; waits out memory latency, then holds
// instr_valid until downstream acks, and selects the next PC from the fed-back control fields.
module pc_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  IMEM_DEPTH   = 1024,
  parameter int                  IMEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic                instr_valid,
  input  logic                instr_ack,
  input  logic                branch_taken,
  input  logic [31:0]         imm_signed,
  input  logic                jump,
  input  logic [31:0]         jmp_signed,
  input  logic                jr,
  input  logic [31:0]         jr_target,
  input  logic                halt,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         retired_count
);

  typedef enum logic [1:0] {S_WAIT, S_VALID, S_HALT, S_FAULT} state_t;

  localparam logic [3:0]          LAT     = 4'(IMEM_LATENCY);
  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(IMEM_DEPTH - 1);
  localparam logic [PC_WIDTH-1:0] DEPTH   = PC_WIDTH'(IMEM_DEPTH);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_valid;
  logic                r_halted;
  logic                r_fault;
  logic [31:0]         r_retired;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_seq_pc;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_nonseq;
  logic                w_oor;

  // Only non-sequential targets are range checked; sequential flow wraps to 0.
  always_comb begin
    w_pc_inc = r_pc + PC_WIDTH'(1);
    w_seq_pc = (r_pc == LAST_PC) ? '0 : w_pc_inc;
    w_nonseq = jr | jump | branch_taken;
    w_target = w_pc_inc;
    if (jr)
      w_target = PC_WIDTH'($signed(jr_target));
    else if (jump)
      w_target = w_pc_inc + PC_WIDTH'($signed(jmp_signed));
    else if (branch_taken)
      w_target = w_pc_inc + PC_WIDTH'($signed(imm_signed));
    w_oor = w_nonseq && (w_target[PC_WIDTH-1] || (w_target >= DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_WAIT;
      r_cnt     <= LAT;
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_VALID: begin
          if (instr_ack) begin
            r_retired <= r_retired + 32'd1;
            r_valid   <= 1'b0;
            if (halt) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else if (w_oor) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pc    <= w_nonseq ? w_target : w_seq_pc;
              r_cnt   <= LAT;
              r_state <= S_WAIT;
            end
          end
        end
        S_HALT:  ;
        S_FAULT: ;
        default: ;
      endcase
    end
  end

  assign pcOut         = r_pc;
  assign instr_valid   = r_valid;
  assign halted        = r_halted;
  assign fault         = r_fault;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (latency 1 and 3) share stimulus and are checked every
// cycle against a behavioural model, with literal expectations for the directed scenarios.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_ack, branch_taken, jump, jr, halt;
  logic [31:0] imm_signed, jmp_signed, jr_target;

  logic [31:0] pc_a, pc_b, ret_a, ret_b;
  logic        vld_a, vld_b, hlt_a, hlt_b, flt_a, flt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.IMEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .pcOut(pc_a), .instr_valid(vld_a), .instr_ack(instr_ack),
    .branch_taken(branch_taken), .imm_signed(imm_signed), .jump(jump), .jmp_signed(jmp_signed),
    .jr(jr), .jr_target(jr_target), .halt(halt), .halted(hlt_a), .fault(flt_a),
    .retired_count(ret_a)
  );

  pc_fetch_unit #(.IMEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .pcOut(pc_b), .instr_valid(vld_b), .instr_ack(instr_ack),
    .branch_taken(branch_taken), .imm_signed(imm_signed), .jump(jump), .jmp_signed(jmp_signed),
    .jr(jr), .jr_target(jr_target), .halt(halt), .halted(hlt_b), .fault(flt_b),
    .retired_count(ret_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a PC, cycles since it was loaded, and sticky halt/fault flags.
  localparam int LATS[2] = '{1, 3};
  localparam longint DEPTH = 1024;
  longint      m_pc[2];
  int          m_age[2];
  bit          m_halt[2], m_fault[2];
  int unsigned m_ret[2];
  bit          m_seen = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint t;
      bit     nonseq;
      if (reset) begin
        m_pc[i] = 0; m_age[i] = 0; m_halt[i] = 0; m_fault[i] = 0; m_ret[i] = 0;
        m_seen = 1'b1;
      end else if (m_halt[i] || m_fault[i]) begin
        // frozen
      end else if (m_age[i] >= LATS[i] && instr_ack) begin
        m_ret[i]++;
        nonseq = 1'b1;
        t = 0;
        if (halt) begin
          m_halt[i] = 1'b1;
          nonseq = 1'b0;
        end else if (jr) t = longint'($signed(jr_target));
        else if (jump) t = m_pc[i] + 1 + longint'($signed(jmp_signed));
        else if (branch_taken) t = m_pc[i] + 1 + longint'($signed(imm_signed));
        else begin
          nonseq = 1'b0;
          m_pc[i] = (m_pc[i] == DEPTH - 1) ? 0 : m_pc[i] + 1;
          m_age[i] = 0;
        end
        if (nonseq) begin
          if (t < 0 || t >= DEPTH) m_fault[i] = 1'b1;
          else begin
            m_pc[i] = t;
            m_age[i] = 0;
          end
        end
      end else if (m_age[i] < 100) begin
        m_age[i]++;
      end
    end
  end

  logic [31:0] d_pc[2], d_ret[2];
  logic        d_vld[2], d_hlt[2], d_flt[2];
  assign d_pc  = '{pc_a, pc_b};
  assign d_ret = '{ret_a, ret_b};
  assign d_vld = '{vld_a, vld_b};
  assign d_hlt = '{hlt_a, hlt_b};
  assign d_flt = '{flt_a, flt_b};

  always @(negedge clk) begin
    if (m_seen) begin
      for (int i = 0; i < 2; i++) begin
        bit ev;
        ev = !m_halt[i] && !m_fault[i] && (m_age[i] >= LATS[i]);
        chk($sformatf("model_pc[%0d]", i), 64'(d_pc[i]), 64'(m_pc[i]));
        chk($sformatf("model_vld[%0d]", i), 64'(d_vld[i]), 64'(ev));
        chk($sformatf("model_halted[%0d]", i), 64'(d_hlt[i]), 64'(m_halt[i]));
        chk($sformatf("model_fault[%0d]", i), 64'(d_flt[i]), 64'(m_fault[i]));
        chk($sformatf("model_retired[%0d]", i), 64'(d_ret[i]), 64'(m_ret[i]));
      end
    end
  end

  task automatic clr();
    instr_ack = 0; branch_taken = 0; jump = 0; jr = 0; halt = 0;
    imm_signed = 0; jmp_signed = 0; jr_target = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    clr();
    reset = 1;
    cyc(n);
    reset = 0;
  endtask

  // Wait (bounded) for instance A to present an instruction, then ack it with the given controls.
  task automatic step_a(input bit h, input bit jr_i, input bit jmp_i, input bit br_i,
                        input logic [31:0] jrt, input logic [31:0] jo, input logic [31:0] io);
    int t = 0;
    while (!vld_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("step_valid_timeout", 64'(vld_a), 64'd1);
    instr_ack = 1; halt = h; jr = jr_i; jump = jmp_i; branch_taken = br_i;
    jr_target = jrt; jmp_signed = jo; imm_signed = io;
    @(negedge clk);
    clr();
  endtask

  function automatic logic [31:0] rand_ofs();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(0, 60)) - 32'd30;
  endfunction

  initial begin
    clr();
    reset = 1;
    cyc(20);
    chk("rst_pc", 64'(pc_a), 0);
    chk("rst_vld", 64'(vld_a), 0);
    chk("rst_ret", 64'(ret_a), 0);
    chk("rst_flt", 64'(flt_b), 0);
    chk("rst_hlt", 64'(hlt_b), 0);

    reset = 0;
    instr_ack = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("seq_pc", 64'(pc_a), 64'(k / 2));
      chk("seq_vld", 64'(vld_a), 64'(k % 2));
    end
    chk("seq_ret4", 64'(ret_a), 4);
    instr_ack = 0;

    step_a(0, 0, 0, 0, 0, 0, 0);
    chk("pc5", 64'(pc_a), 5);
    step_a(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFD);
    chk("br_back", 64'(pc_a), 3);
    step_a(0, 0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 1, 0, 0, 32'd4);
    chk("br_fwd", 64'(pc_a), 10);

    do_reset(2);
    step_a(0, 0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0, 0);
    chk("pc2", 64'(pc_a), 2);
    step_a(0, 0, 1, 1, 0, 32'd7, 32'd100);
    chk("jump_wins", 64'(pc_a), 10);

    do_reset(2);
    step_a(0, 0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0, 0);
    step_a(0, 1, 0, 0, 32'h400, 0, 0);
    chk("jr_fault", 64'(flt_a), 1);
    chk("jr_pc", 64'(pc_a), 2);
    chk("jr_vld", 64'(vld_a), 0);
    instr_ack = 1;
    cyc(4);
    instr_ack = 0;
    chk("fault_frozen_pc", 64'(pc_a), 2);
    chk("fault_frozen_ret", 64'(ret_a), 3);
    chk("fault_frozen_vld", 64'(vld_a), 0);
    do_reset(1);
    chk("fault_clr", 64'(flt_a), 0);
    chk("fault_clr_pc", 64'(pc_a), 0);

    step_a(0, 0, 0, 1, 0, 0, 32'd1021);
    chk("pc1022", 64'(pc_a), 1022);
    step_a(0, 0, 0, 0, 0, 0, 0);
    chk("pc1023", 64'(pc_a), 1023);
    step_a(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 64'(pc_a), 0);
    chk("wrap_flt", 64'(flt_a), 0);

    do_reset(1);
    step_a(0, 0, 0, 1, 0, 0, 32'd5);
    chk("pc6", 64'(pc_a), 6);
    step_a(1, 0, 1, 0, 0, 32'd3, 0);
    chk("halt_hlt", 64'(hlt_a), 1);
    chk("halt_pc", 64'(pc_a), 6);
    chk("halt_ret", 64'(ret_a), 2);
    instr_ack = 1;
    cyc(5);
    instr_ack = 0;
    chk("halt_ret_frozen", 64'(ret_a), 2);
    chk("halt_pc_frozen", 64'(pc_a), 6);

    do_reset(1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat3_vld", 64'(vld_b), 64'(k == 3));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lat3_hold_vld", 64'(vld_b), 1);
      chk("lat3_hold_pc", 64'(pc_b), 0);
    end
    instr_ack = 1;
    @(negedge clk);
    instr_ack = 0;
    chk("lat3_adv", 64'(pc_b), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("lat3_rst_pc", 64'(pc_b), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat3_rst_vld", 64'(vld_b), 64'(k == 3));
    end

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ((hlt_a || flt_a) && (hlt_b || flt_b)) reset = ($urandom_range(0, 7) == 0);
      else reset = ($urandom_range(0, 299) == 0);
      instr_ack    = ($urandom_range(0, 9) < 6);
      branch_taken = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 6) == 0);
      jr           = ($urandom_range(0, 9) == 0);
      halt         = ($urandom_range(0, 49) == 0);
      imm_signed   = rand_ofs();
      jmp_signed   = rand_ofs();
      jr_target    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
    end
    clr();
    reset = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
